display_scheduler: RTL and testbench

Sequences all transactions to the MAX7219 output path. It arbitrates between three requesters: the periodic driver re-configuration, intensity changes, and time refreshes triggered by the 1 Hz and set strobes. Only one strobe/ack transaction is outstanding at a time. It sits between the clock timing/control logic and `output_wrapper`, replacing direct strobe generation to the display.

---
 rtl/display_scheduler_if.sv | 31 +++
 rtl/display_scheduler.sv | 163 ++++++++++++++++
 tb/tb_display_scheduler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scheduler_if.sv
// Handshake bundle between display_scheduler (master) and the MAX7219 output path (slave).
// The master starts one transaction per strobe; the slave reports busy and a one-cycle ack.
interface display_scheduler_if;
   logic       display_stb;
   logic       write_config;
   logic       write_intensity;
   logic [3:0] intensity;
   logic       timeout;
   logic       display_busy;
   logic       display_ack;

   modport master (
      output display_stb,
      output write_config,
      output write_intensity,
      output intensity,
      output timeout,
      input  display_busy,
      input  display_ack
   );

   modport slave (
      input  display_stb,
      input  write_config,
      input  write_intensity,
      input  intensity,
      input  timeout,
      output display_busy,
      output display_ack
   );
endinterface

// File: rtl/display_scheduler.sv
// Arbitrates config, intensity and time-refresh requests onto the display output path,
// keeping at most one strobe/ack transaction outstanding, with an ack timeout.
module display_scheduler #(
   parameter int unsigned REFRESH_SECONDS = 60,
   parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_1hz_stb,
   input  logic                i_clk_set_stb,
   input  logic                i_clk_set,
   input  logic [3:0]          i_intensity,
   display_scheduler_if.master disp
);

   localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW_RAW = $clog2(REFRESH_SECONDS + 1);
   localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;

   localparam bit            REF_EN   = (REFRESH_SECONDS != 0);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_SECONDS - 1);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT_ACK
   } state_e;

   state_e        state_q, state_d;
   logic          cfg_pend_q, cfg_pend_d;
   logic          time_pend_q, time_pend_d;
   logic [3:0]    last_int_q, last_int_d;
   logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

   logic          display_stb_q, display_stb_d;
   logic          write_config_q, write_config_d;
   logic          write_intensity_q, write_intensity_d;
   logic [3:0]    intensity_q, intensity_d;
   logic          timeout_q, timeout_d;

   logic int_req;
   logic cfg_set, time_set;
   logic cfg_clr, time_clr;
   logic cfg_retry, time_retry;

   assign int_req  = (i_intensity != last_int_q);
   assign time_set = i_1hz_stb | (i_clk_set_stb & i_clk_set);

   // NOTE: every signal written here gets a default first, so no path can leave
   // a value unassigned and infer a latch.
   always_comb begin
      state_d           = state_q;
      last_int_d        = last_int_q;
      refresh_cnt_d     = refresh_cnt_q;
      tmo_cnt_d         = tmo_cnt_q;
      display_stb_d     = 1'b0;
      timeout_d         = 1'b0;
      write_config_d    = write_config_q;
      write_intensity_d = write_intensity_q;
      intensity_d       = intensity_q;
      cfg_set           = 1'b0;
      cfg_clr           = 1'b0;
      time_clr          = 1'b0;
      cfg_retry         = 1'b0;
      time_retry        = 1'b0;

      if (REF_EN && i_1hz_stb) begin
         if (refresh_cnt_q == REF_LAST) begin
            refresh_cnt_d = '0;
            cfg_set       = 1'b1;
         end else begin
            refresh_cnt_d = refresh_cnt_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if ((cfg_pend_q || int_req || time_pend_q) && !disp.display_busy) begin
               display_stb_d = 1'b1;
               intensity_d   = i_intensity;
               tmo_cnt_d     = '0;
               state_d       = ST_WAIT_ACK;
               if (cfg_pend_q) begin
                  write_config_d    = 1'b1;
                  write_intensity_d = 1'b0;
                  cfg_clr           = 1'b1;
               end else if (int_req) begin
                  write_config_d    = 1'b0;
                  write_intensity_d = 1'b1;
               end else begin
                  write_config_d    = 1'b0;
                  write_intensity_d = 1'b0;
                  time_clr          = 1'b1;
               end
            end
         end

         ST_WAIT_ACK: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            // An ack coinciding with our own strobe cannot belong to this transaction.
            if (disp.display_ack && !display_stb_q) begin
               if (write_config_q || write_intensity_q) begin
                  last_int_d = intensity_q;
               end
               write_config_d    = 1'b0;
               write_intensity_d = 1'b0;
               state_d           = ST_IDLE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               timeout_d         = 1'b1;
               cfg_retry         = write_config_q;
               time_retry        = !write_config_q && !write_intensity_q;
               write_config_d    = 1'b0;
               write_intensity_d = 1'b0;
               state_d           = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // A set arriving in the same cycle as the grant-clear wins.
      cfg_pend_d  = (cfg_pend_q & ~cfg_clr) | cfg_set | cfg_retry;
      time_pend_d = (time_pend_q & ~time_clr) | time_set | time_retry;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q           <= ST_IDLE;
         cfg_pend_q        <= 1'b1;
         time_pend_q       <= 1'b0;
         last_int_q        <= 4'h0;
         refresh_cnt_q     <= '0;
         tmo_cnt_q         <= '0;
         display_stb_q     <= 1'b0;
         write_config_q    <= 1'b0;
         write_intensity_q <= 1'b0;
         intensity_q       <= 4'h0;
         timeout_q         <= 1'b0;
      end else begin
         state_q           <= state_d;
         cfg_pend_q        <= cfg_pend_d;
         time_pend_q       <= time_pend_d;
         last_int_q        <= last_int_d;
         refresh_cnt_q     <= refresh_cnt_d;
         tmo_cnt_q         <= tmo_cnt_d;
         display_stb_q     <= display_stb_d;
         write_config_q    <= write_config_d;
         write_intensity_q <= write_intensity_d;
         intensity_q       <= intensity_d;
         timeout_q         <= timeout_d;
      end
   end

   assign disp.display_stb     = display_stb_q;
   assign disp.write_config    = write_config_q;
   assign disp.write_intensity = write_intensity_q;
   assign disp.intensity       = intensity_q;
   assign disp.timeout         = timeout_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: the driver predicts transactions from the
// request rules; a monitor/responder pops and checks them as strobes appear.
module tb_display_scheduler;

   localparam int REF = 3;
   localparam int TMO = 16;

   typedef enum {K_CFG, K_INT, K_TIME} kind_e;
   typedef struct {
      kind_e      kind;
      logic [3:0] val;
   } txn_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_1hz_stb = 1'b0;
   logic       i_clk_set_stb = 1'b0;
   logic       i_clk_set = 1'b0;
   logic [3:0] i_intensity = 4'h0;
   logic       mon_ack = 1'b0;
   logic       drv_ack = 1'b0;
   logic       busy_at_edge = 1'b0;

   display_scheduler_if dif ();

   assign dif.display_ack = mon_ack | drv_ack;

   display_scheduler #(
      .REFRESH_SECONDS(REF),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_1hz_stb    (i_1hz_stb),
      .i_clk_set_stb(i_clk_set_stb),
      .i_clk_set    (i_clk_set),
      .i_intensity  (i_intensity),
      .disp         (dif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) busy_at_edge <= dif.display_busy;

   int   checks = 0;
   int   failures = 0;
   txn_t exp_q[$];

   // Reference-model state
   logic [3:0] m_last = 4'h0;
   int         m_ref_cnt = 0;

   // Monitor/responder state
   bit   outstanding = 0;
   bit   withhold = 0;
   bit   force_withhold = 0;
   bit   tmo_en = 0;
   int   cyc = 0;
   int   stb_cyc = 0;
   int   ack_at = 0;
   int   last_ack_cyc = -100;
   txn_t cur;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int kbits(input kind_e k);
      case (k)
         K_CFG:   return 2;
         K_INT:   return 1;
         default: return 0;
      endcase
   endfunction

   // An aborted transaction is retried; a failed intensity write is absorbed by a queued config write.
   function automatic void reinsert(input txn_t t);
      bit has_cfg = 0;
      foreach (exp_q[i]) if (exp_q[i].kind == K_CFG) has_cfg = 1;
      if (!(t.kind == K_INT && has_cfg)) exp_q.push_front(t);
   endfunction

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_ack) begin
            mon_ack     = 1'b0;
            outstanding = 0;
         end
         if (!rst_n) begin
            outstanding = 0;
         end else begin
            if (dif.timeout) begin
               check("timeout_expected", int'(outstanding && withhold), 1);
               if (outstanding && withhold) begin
                  check("timeout_latency", cyc - stb_cyc, TMO);
                  reinsert(cur);
                  outstanding = 0;
               end
            end
            if (dif.display_stb) begin
               check("stb_while_busy", int'(busy_at_edge), 0);
               check("stb_overlap", int'(outstanding), 0);
               check("stb_gap_after_ack", int'(cyc >= last_ack_cyc + 2), 1);
               check("stb_expected", int'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) cur = exp_q.pop_front();
               else cur = '{kind: K_TIME, val: 4'h0};
               check("stb_kind", int'({dif.write_config, dif.write_intensity}), kbits(cur.kind));
               check("stb_intensity", int'(dif.intensity), int'(cur.val));
               outstanding    = 1;
               stb_cyc        = cyc;
               withhold       = force_withhold || (tmo_en && $urandom_range(0, 4) == 0);
               force_withhold = 0;
               ack_at         = cyc + int'($urandom_range(1, 6));
            end else if (outstanding) begin
               if (withhold) begin
                  if (cyc > stb_cyc + TMO) begin
                     check("timeout_seen_at", cyc - 1 - stb_cyc, TMO);
                     outstanding = 0;
                  end
               end else if (cyc == ack_at) begin
                  check("held_kind", int'({dif.write_config, dif.write_intensity}), kbits(cur.kind));
                  check("held_intensity", int'(dif.intensity), int'(cur.val));
                  mon_ack      = 1'b1;
                  last_ack_cyc = cyc;
               end
            end
         end
      end
   end

   // Applies one event cycle and predicts the resulting transactions from the request rules.
   task automatic step(input logic [3:0] v, input bit hz, input bit sstb, input bit sset,
                       input int busy_cyc);
      bit wrap = 0;
      bit chg  = (v != m_last);
      if (hz) begin
         m_ref_cnt++;
         if (m_ref_cnt == REF) begin
            m_ref_cnt = 0;
            wrap      = 1;
         end
      end
      if (busy_cyc == 0) begin
         if (chg)  exp_q.push_back('{kind: K_INT, val: v});
         if (wrap) exp_q.push_back('{kind: K_CFG, val: v});
      end else begin
         if (wrap)     exp_q.push_back('{kind: K_CFG, val: v});
         else if (chg) exp_q.push_back('{kind: K_INT, val: v});
      end
      if (hz || (sstb && sset)) exp_q.push_back('{kind: K_TIME, val: v});
      m_last = v;

      i_intensity      = v;
      i_1hz_stb        = hz;
      i_clk_set_stb    = sstb;
      i_clk_set        = sset;
      dif.display_busy = (busy_cyc > 0);
      @(negedge clk);
      i_1hz_stb     = 1'b0;
      i_clk_set_stb = 1'b0;
      for (int i = 1; i < busy_cyc; i++) @(negedge clk);
      dif.display_busy = 1'b0;
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((exp_q.size() != 0 || outstanding) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("quiet_within_budget", int'(n < 600), 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_stb();
      int n = 0;
      while (dif.display_stb !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("stb_within_budget", int'(n < 300), 1);
   endtask

   initial begin : driver
      logic [3:0] v;
      dif.display_busy = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_outputs", int'({dif.display_stb, dif.write_config, dif.write_intensity,
                                   dif.intensity, dif.timeout}), 0);
      exp_q.push_back('{kind: K_CFG, val: 4'h0});
      rst_n = 1'b1;
      @(negedge clk);
      check("first_stb_config", int'({dif.display_stb, dif.write_config}), 3);
      wait_quiet();

      // Intensity to A, then a repeat of A that must not transact
      step(4'hA, 0, 0, 0, 0);
      wait_quiet();
      step(4'hA, 0, 0, 0, 0);
      wait_quiet();

      // Seconds strobe with an intensity change, then two more seconds to hit the refresh
      step(4'h3, 1, 0, 0, 0);
      wait_quiet();
      step(4'h3, 1, 0, 0, 0);
      wait_quiet();
      step(4'h3, 1, 0, 0, 0);
      wait_quiet();

      // Set strobe qualified and unqualified
      step(4'h3, 0, 1, 1, 0);
      wait_quiet();
      step(4'h3, 0, 1, 0, 0);
      wait_quiet();

      // Withheld ack: timeout then retry of the same kind
      force_withhold = 1;
      step(4'h7, 0, 0, 0, 0);
      wait_quiet();
      force_withhold = 1;
      step(4'h7, 0, 1, 1, 0);
      wait_quiet();

      // Long busy holds off the strobe
      step(4'h1, 1, 0, 0, 10);
      wait_quiet();

      // Intensity change while a transaction is outstanding
      v = m_last ^ 4'h5;
      step(v, 0, 0, 0, 0);
      wait_stb();
      v = v ^ 4'h3;
      exp_q.push_back('{kind: K_INT, val: v});
      m_last      = v;
      i_intensity = v;
      wait_quiet();

      // Randomized events with occasional busy holds and withheld acks
      tmo_en = 1;
      for (int i = 0; i < 40; i++) begin
         v = ($urandom_range(0, 1) == 1) ? m_last : 4'($urandom_range(0, 15));
         step(v, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
         wait_quiet();
      end
      tmo_en = 0;

      // Reset while waiting for ack; a late ack after release must be ignored
      v = m_last ^ 4'h9;
      step(v, 0, 0, 0, 0);
      wait_stb();
      @(negedge clk);
      #1;
      rst_n            = 1'b0;
      dif.display_busy = 1'b1;
      #1;
      check("reset_mid_txn_outputs", int'({dif.display_stb, dif.write_config, dif.write_intensity,
                                           dif.intensity, dif.timeout}), 0);
      exp_q.delete();
      exp_q.push_back('{kind: K_CFG, val: v});
      m_last    = v;
      m_ref_cnt = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drv_ack = 1'b1;
      @(negedge clk);
      drv_ack = 1'b0;
      @(negedge clk);
      dif.display_busy = 1'b0;
      wait_quiet();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
